// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: state encodings, fixed
// oversampling sample points and the baud divider computation.
package uart_rx_pkg;

    // Oversampling factor; the sample points below assume exactly 16.
    localparam int unsigned OVS_DEFAULT = 16;

    // Mid-bit sample point inside the start bit, in ticks.
    localparam logic [3:0] MID_SAMPLE = 4'd7;

    // Last tick of a bit period; data/parity/stop are sampled here,
    // which lands mid-bit because the start bit was sampled mid-bit.
    localparam logic [3:0] LAST_SAMPLE = 4'd15;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    // Clock cycles per oversampling tick, rounded down, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned ovs);
        int unsigned d;
        d = clk_hz / (baud * ovs);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator shared by the UART transmitter and receiver.
// Free-running divider; tick is high for one cycle at each wrap. clr
// restarts the divider so the receiver can align bit phase to a start edge.
module baud_tick_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OVS    = OVS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVS);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Divider counter: 0..DIV-1, restarted by reset or clr.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), 16x
// oversampling. Delivers bytes on a valid/ready handshake; flags framing
// errors, overruns and (optionally) parity errors as one-cycle pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned OVS    = OVS_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    logic   rxd_meta, rxd_sync, rxd_prev;
    logic   fall;
    logic   tick;
    logic   tick_clr;
    state_e state;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] shreg;
    logic       brk;

    // Two-flop synchroniser plus one history flop for falling-edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    assign fall     = rxd_prev & ~rxd_sync;
    assign tick_clr = (state == StIdle) && fall;

    baud_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (OVS)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Frame FSM with registered outputs and the consumer handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            brk       <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (fall) begin
                        state <= StStart;
                        scnt  <= '0;
                    end
                end

                StStart: begin
                    if (tick) begin
                        if (scnt == MID_SAMPLE) begin
                            // Line back high at mid start bit: a glitch, not a frame.
                            if (!rxd_sync) begin
                                state <= StData;
                                scnt  <= '0;
                                bcnt  <= '0;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end

                StData: begin
                    if (tick) begin
                        if (scnt == LAST_SAMPLE) begin
                            shreg <= {rxd_sync, shreg[7:1]};
                            bcnt  <= bcnt + 3'd1;
                            scnt  <= '0;
                            if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= StParity;
`else
                                state <= StStop;
`endif
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        if (scnt == LAST_SAMPLE) begin
                            // Even parity: data bits plus parity bit must XOR to 0.
                            parity_err <= ^{shreg, rxd_sync};
                            state      <= StStop;
                            scnt       <= '0;
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end
`endif

                StStop: begin
                    if (brk) begin
                        // Break: hold here until the line idles high again.
                        if (rxd_sync) begin
                            brk   <= 1'b0;
                            state <= StIdle;
                        end
                    end else if (tick) begin
                        if (scnt == LAST_SAMPLE) begin
                            if (rxd_sync) begin
                                state <= StIdle;
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                brk       <= 1'b1;
                            end
                        end else begin
                            scnt <= scnt + 4'd1;
                        end
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule
